// File: rtl/dino_pkg.sv
// Shared game definitions: FSM state encodings, sprite and screen sizes,
// and the sprite overlap test used by the motion controller.
package dino_pkg;

   typedef enum logic [1:0] {G_IDLE, G_RUN, G_OVER} game_state_t;
   typedef enum logic [1:0] {J_GROUND, J_RISE, J_FALL} jump_state_t;

   localparam int COORD_W  = 12;
   localparam int DINO_W   = 50;
   localparam int DINO_H   = 60;
   localparam int OBST_W   = 50;
   localparam int OBST_H   = 120;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   // Inclusive overlap of dino [dx,dx+W]x[dy-H,dy] and obstacle
   // [ox,ox+W]x[oy-H,oy]. Subtractions are moved to the other side of each
   // compare so the 13-bit math never wraps.
   function automatic logic rect_hit(input logic [COORD_W-1:0] dx,
                                     input logic [COORD_W-1:0] dy,
                                     input logic [COORD_W-1:0] ox,
                                     input logic [COORD_W-1:0] oy);
      logic [COORD_W:0] dxe, dye, oxe, oye;
      dxe = {1'b0, dx};
      dye = {1'b0, dy};
      oxe = {1'b0, ox};
      oye = {1'b0, oy};
      return (dxe <= oxe + 13'(OBST_W)) && (oxe <= dxe + 13'(DINO_W)) &&
             (dye <= oye + 13'(DINO_H)) && (oye <= dye + 13'(OBST_H));
   endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizer chain followed by a rising-edge detector producing a
// one-cycle pulse on the first cycle the synchronized level reads 1.
module edge_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic pulse
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   logic              level;

   assign level = sync_q[STAGES-1];
   assign pulse = level & ~prev_q;

   // Shift the input through the sync chain and remember the last level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= STAGES'({sync_q, din});
         prev_q <= level;
      end
   end

endmodule

// File: rtl/dino_motion_ctrl.sv
// Dino runner motion controller: game and jump FSMs advanced once per VGA
// frame, obstacle scrolling with score counting, and collision detection.
module dino_motion_ctrl
   import dino_pkg::*;
#(
   parameter int GROUND_Y     = 320,
   parameter int DINO_X       = 240,
   parameter int JUMP_H       = 150,
   parameter int JUMP_STEP    = 6,
   parameter int OBST_STEP    = 4,
   parameter int OBST_START_X = 680
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        screen_ready,
   input  logic        jump_btn,
   output logic [31:0] x_coor,
   output logic [31:0] y_coor,
   output logic [31:0] x_coor_obstacle,
   output logic [31:0] y_coor_obstacle,
   output logic        game_over,
   output logic [15:0] score
);

   localparam logic [COORD_W-1:0] GY   = COORD_W'(GROUND_Y);
   localparam logic [COORD_W-1:0] APEX = COORD_W'(GROUND_Y - JUMP_H);
   localparam logic [COORD_W-1:0] JS   = COORD_W'(JUMP_STEP);
   localparam logic [COORD_W-1:0] OS   = COORD_W'(OBST_STEP);
   localparam logic [COORD_W-1:0] OSX  = COORD_W'(OBST_START_X);
   localparam logic [COORD_W-1:0] DX   = COORD_W'(DINO_X);

   logic press, tick;

   // Button is asynchronous: full two-flop synchronizer before edge detect.
   edge_sync #(.STAGES(2)) u_btn_sync (
      .clk   (clk),
      .reset (reset),
      .din   (jump_btn),
      .pulse (press)
   );

   // screen_ready already lives in the clk domain; one register is enough
   // and keeps the frame-to-motion latency at two cycles.
   edge_sync #(.STAGES(1)) u_frame_sync (
      .clk   (clk),
      .reset (reset),
      .din   (screen_ready),
      .pulse (tick)
   );

   game_state_t        gst;
   jump_state_t        jst, j_nx;
   logic [COORD_W-1:0] y_q, xo_q, y_nx, xo_nx;
   logic [15:0]        score_q, sc_nx;
   logic               over_q, pend_q, press_any, hit;

   // A press landing on the tick cycle itself still counts for that tick.
   assign press_any = pend_q | press;

   // Next RUN-frame positions, jump state, score and collision.
   always_comb begin
      j_nx  = jst;
      y_nx  = y_q;
      xo_nx = xo_q;
      sc_nx = score_q;
      if (jst == J_RISE || (jst == J_GROUND && press_any)) begin
         j_nx = J_RISE;
         if ({1'b0, y_q} <= {1'b0, APEX} + {1'b0, JS}) begin
            y_nx = APEX;
            j_nx = J_FALL;
         end else begin
            y_nx = y_q - JS;
         end
      end else if (jst == J_FALL) begin
         if ({1'b0, y_q} + {1'b0, JS} >= {1'b0, GY}) begin
            y_nx = GY;
            j_nx = J_GROUND;
         end else begin
            y_nx = y_q + JS;
         end
      end
      if (xo_q < OS) begin
         xo_nx = OSX;
         if (score_q != 16'hFFFF) sc_nx = score_q + 16'd1;
      end else begin
         xo_nx = xo_q - OS;
      end
      hit = rect_hit(DX, y_nx, xo_nx, GY);
   end

   // Game FSM with the press-pending flag; all motion happens on tick.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gst     <= G_IDLE;
         jst     <= J_GROUND;
         y_q     <= GY;
         xo_q    <= OSX;
         score_q <= '0;
         over_q  <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         pend_q <= tick ? 1'b0 : (pend_q | press);
         if (tick) begin
            case (gst)
               G_IDLE: if (press_any) gst <= G_RUN;
               G_RUN: begin
                  jst     <= j_nx;
                  y_q     <= y_nx;
                  xo_q    <= xo_nx;
                  score_q <= sc_nx;
                  if (hit) begin
                     gst    <= G_OVER;
                     over_q <= 1'b1;
                  end
               end
               G_OVER: if (press_any) begin
                  gst     <= G_RUN;
                  jst     <= J_GROUND;
                  y_q     <= GY;
                  xo_q    <= OSX;
                  score_q <= '0;
                  over_q  <= 1'b0;
               end
               default: gst <= G_IDLE;
            endcase
         end
      end
   end

   assign x_coor          = 32'(DX);
   assign y_coor          = 32'(y_q);
   assign x_coor_obstacle = 32'(xo_q);
   assign y_coor_obstacle = 32'(GY);
   assign game_over       = over_q;
   assign score           = score_q;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Bench for dino_motion_ctrl: a default instance plus two instances with the
// dino moved off the obstacle path so scoring can be exercised.
module tb_dino_motion_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic screen_ready = 1'b0;
   logic jump_btn = 1'b0;

   always #5 clk = ~clk;

   logic [31:0] xa, ya, xoa, yoa, xb, yb, xob, yob, xc, yc, xoc, yoc;
   logic        ova, ovb, ovc;
   logic [15:0] sca, scb, scc;

   dino_motion_ctrl dut_a (
      .clk(clk), .reset(reset), .screen_ready(screen_ready), .jump_btn(jump_btn),
      .x_coor(xa), .y_coor(ya), .x_coor_obstacle(xoa), .y_coor_obstacle(yoa),
      .game_over(ova), .score(sca));

   dino_motion_ctrl #(.DINO_X(800), .OBST_START_X(683)) dut_b (
      .clk(clk), .reset(reset), .screen_ready(screen_ready), .jump_btn(jump_btn),
      .x_coor(xb), .y_coor(yb), .x_coor_obstacle(xob), .y_coor_obstacle(yob),
      .game_over(ovb), .score(scb));

   dino_motion_ctrl #(.DINO_X(800)) dut_c (
      .clk(clk), .reset(reset), .screen_ready(screen_ready), .jump_btn(jump_btn),
      .x_coor(xc), .y_coor(yc), .x_coor_obstacle(xoc), .y_coor_obstacle(yoc),
      .game_over(ovc), .score(scc));

   // Reference model state: g 0/1/2 = idle/run/over, j 0/1/2 = ground/rise/fall.
   typedef struct {int g; int j; int y; int xo; int sc; int dx; int sx;} mst_t;
   typedef struct {int y; int xo; int sc; int ov;} exp_t;

   mst_t ma, mb, mc;
   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic mst_t mreset(input int dx, input int sx);
      mst_t s;
      s.g = 0; s.j = 0; s.y = 320; s.xo = sx; s.sc = 0; s.dx = dx; s.sx = sx;
      return s;
   endfunction

   function automatic mst_t mstep(input mst_t s, input bit p);
      mst_t n = s;
      if (s.g == 0) begin
         if (p) n.g = 1;
      end else if (s.g == 2) begin
         if (p) begin
            n.g = 1; n.j = 0; n.y = 320; n.xo = s.sx; n.sc = 0;
         end
      end else begin
         if (n.j == 0 && p) n.j = 1;
         if (n.j == 1) begin
            n.y = n.y - 6;
            if (n.y <= 170) begin n.y = 170; n.j = 2; end
         end else if (n.j == 2) begin
            n.y = n.y + 6;
            if (n.y >= 320) begin n.y = 320; n.j = 0; end
         end
         if (n.xo < 4) begin
            n.xo = s.sx;
            if (n.sc < 65535) n.sc = n.sc + 1;
         end else n.xo = n.xo - 4;
         if (n.dx <= n.xo + 50 && n.xo <= n.dx + 50 && n.y - 60 <= 320 && 200 <= n.y)
            n.g = 2;
      end
      return n;
   endfunction

   function automatic exp_t to_exp(input mst_t s);
      exp_t e;
      e.y = s.y; e.xo = s.xo; e.sc = s.sc; e.ov = (s.g == 2) ? 1 : 0;
      return e;
   endfunction

   task automatic cmp_dut(input string nm, input exp_t e, input logic [31:0] y,
                          input logic [31:0] xo, input logic [15:0] sc, input logic ov);
      chk({nm, ".y"}, y, e.y);
      chk({nm, ".xo"}, xo, e.xo);
      chk({nm, ".score"}, 32'(sc), e.sc);
      chk({nm, ".over"}, 32'(ov), e.ov);
   endtask

   // One frame: optional button press, then screen_ready high for 'hold'
   // cycles. Expected results are queued when the frame starts.
   task automatic tick(input bit press, input int hold, input bit lat);
      int old_xo;
      exp_t e;
      if (press) begin
         @(negedge clk) jump_btn = 1'b1;
         repeat (4) @(negedge clk);
         jump_btn = 1'b0;
         repeat (4) @(negedge clk);
      end
      @(negedge clk);
      old_xo = ma.xo;
      ma = mstep(ma, press);
      mb = mstep(mb, press);
      mc = mstep(mc, press);
      sb.push_back(to_exp(ma));
      sb.push_back(to_exp(mb));
      sb.push_back(to_exp(mc));
      screen_ready = 1'b1;
      for (int i = 1; i <= hold; i++) begin
         @(negedge clk);
         if (lat && i == 1) chk("lat_before", xoa, old_xo);
         if (lat && i == 2) chk("lat_after", xoa, ma.xo);
      end
      screen_ready = 1'b0;
      repeat (3) @(negedge clk);
      e = sb.pop_front(); cmp_dut("a", e, ya, xoa, sca, ova);
      e = sb.pop_front(); cmp_dut("b", e, yb, xob, scb, ovb);
      e = sb.pop_front(); cmp_dut("c", e, yc, xoc, scc, ovc);
   endtask

   task automatic models_reset();
      ma = mreset(240, 680);
      mb = mreset(800, 683);
      mc = mreset(800, 680);
   endtask

   initial begin
      models_reset();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst.x", xa, 240);
      chk("rst.y", ya, 320);
      chk("rst.xo", xoa, 680);
      chk("rst.yo", yoa, 320);
      chk("rst.score", 32'(sca), 0);
      chk("rst.over", 32'(ova), 0);

      // Idle frames without a press: nothing moves.
      repeat (3) tick(1'b0, 3, 1'b0);
      chk("idle.xo", xoa, 680);

      // Start, then a long screen_ready pulse: one step and two-cycle latency.
      tick(1'b1, 3, 1'b0);
      chk("start.xo", xoa, 680);
      tick(1'b0, 100, 1'b1);
      chk("run.xo", xoa, 676);

      // Jump; an extra press mid-rise is ignored.
      for (int k = 1; k <= 50; k++) begin
         tick(k == 1 || k == 10, 3, 1'b0);
         if (k == 25) chk("apex.y", ya, 170);
      end
      chk("land.y", ya, 320);
      chk("land.xo", xoa, 476);

      // Run into the obstacle without jumping.
      for (int k = 0; k < 60 && ma.g != 2; k++) tick(1'b0, 3, 1'b0);
      chk("hit.over", 32'(ova), 1);
      chk("hit.xo", xoa, 288);
      repeat (2) tick(1'b0, 3, 1'b0);
      chk("frozen.xo", xoa, 288);

      // Restart from OVER.
      tick(1'b1, 3, 1'b0);
      chk("restart.over", 32'(ova), 0);
      chk("restart.xo", xoa, 680);
      chk("restart.score", 32'(sca), 0);

      // Jump and reset asynchronously mid-rise at y=200.
      for (int k = 1; k <= 20; k++) tick(k == 1, 3, 1'b0);
      chk("midrise.y", ya, 200);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("async.y", ya, 320);
      chk("async.xo", xoa, 680);
      chk("async.x", xa, 240);
      chk("async.over", 32'(ova), 0);
      chk("async.score", 32'(sca), 0);
      models_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Long run: obstacle wrap boundaries on the off-path instances.
      tick(1'b1, 3, 1'b0);
      for (int k = 1; k <= 172; k++) begin
         tick(1'b0, 3, 1'b0);
         if (k == 98)  chk("a.hit98", 32'(ova), 1);
         if (k == 169) chk("c.x4", xoc, 4);
         if (k == 170) begin
            chk("c.x0", xoc, 0);
            chk("c.sc0", 32'(scc), 0);
            chk("b.x3", xob, 3);
         end
         if (k == 171) begin
            chk("c.wrap", xoc, 680);
            chk("c.sc1", 32'(scc), 1);
            chk("b.wrap", xob, 683);
            chk("b.sc1", 32'(scb), 1);
         end
      end
      chk("a.frozen", xoa, 288);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
